wptr_handler_ctrl: RTL

Write-side pointer and flag controller for the CDC FIFO. It runs in the write clock domain and pairs with the read-side pointer handler. It keeps the binary and Gray write pointers and brings the read Gray pointer into the write domain through a synchronizer. From these it produces registered full, almost_full and occupancy outputs plus a sticky overflow flag. The Gray write pointer it outputs is what the read side synchronizes for its empty calculation.

---
 rtl/fifo_cdc_pkg.sv | 27 ++
 rtl/sync_ff_chain.sv | 30 +++
 rtl/wptr_handler_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/fifo_cdc_pkg.sv
// Shared CDC FIFO helpers: pointer width derivation and Gray conversions.
package fifo_cdc_pkg;

  localparam int unsigned ADDR_WIDTH_DEFAULT = 3;
  localparam int unsigned PW_DEFAULT         = ADDR_WIDTH_DEFAULT + 1;
  localparam int unsigned MAX_PW             = 32;

  // Pointer carries one extra wrap bit beyond the RAM address.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [MAX_PW-1:0] bin2gray(input logic [MAX_PW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [MAX_PW-1:0] gray2bin(input logic [MAX_PW-1:0] gray);
    logic [MAX_PW-1:0] bin;
    bin = gray;
    for (int i = 1; i < int'(MAX_PW); i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-bit flop-chain synchronizer with synchronous active-high reset.
module sync_ff_chain #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Plain shift chain; nothing sits between stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/wptr_handler_ctrl.sv
// Write-side pointer and flag controller for the CDC FIFO.
module wptr_handler_ctrl
  import fifo_cdc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH        = ADDR_WIDTH_DEFAULT,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned ALMOST_FULL_LEVEL = 6
) (
  input  logic                  write_clk,
  input  logic                  write_rst,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH:0]   read_gray_pointer,
  output logic                  write_accept,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH:0]   write_pointer,
  output logic [ADDR_WIDTH:0]   write_gray_pointer,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   write_level,
  output logic                  overflow,
  input  logic                  overflow_clear
);

  localparam int unsigned PW = ptr_width(ADDR_WIDTH);

  logic [PW-1:0] rsync;
  logic [PW-1:0] rbin;
  logic [PW-1:0] wptr_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] level_next;
  logic          full_next;
  logic          almost_full_next;

  // Bring the read Gray pointer into the write domain.
  sync_ff_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (write_clk),
    .rst (write_rst),
    .d   (read_gray_pointer),
    .q   (rsync)
  );

  // Strobe is held low in reset so no write lands while pointers are clearing.
  assign write_accept = write_enable & ~full & ~write_rst;
  assign write_addr   = write_pointer[ADDR_WIDTH-1:0];

  // Look-ahead pointer, occupancy and flag computation.
  always_comb begin
    wptr_next        = write_pointer + PW'(write_accept);
    wgray_next       = PW'(bin2gray(MAX_PW'(wptr_next)));
    rbin             = PW'(gray2bin(MAX_PW'(rsync)));
    level_next       = wptr_next - rbin;
    full_next        = (wgray_next == {~rsync[PW-1:PW-2], rsync[PW-3:0]});
    almost_full_next = (level_next >= PW'(ALMOST_FULL_LEVEL));
  end

  // Pointer, flag and sticky-overflow registers.
  always_ff @(posedge write_clk) begin
    if (write_rst) begin
      write_pointer      <= '0;
      write_gray_pointer <= '0;
      full               <= 1'b0;
      almost_full        <= 1'b0;
      write_level        <= '0;
      overflow           <= 1'b0;
    end else begin
      write_pointer      <= wptr_next;
      write_gray_pointer <= wgray_next;
      full               <= full_next;
      almost_full        <= almost_full_next;
      write_level        <= level_next;
      if (write_enable && full) begin
        overflow <= 1'b1;
      end else if (overflow_clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
